alu_phase_sequencer: RTL and testbench

Single-requester controller that sequences one operation at a time through the 16-bit adiabatic ALU datapath. It latches a request, holds operands and opcode stable on the ALU inputs, and generates the four-phase power-clock enables (clkpos, clkpos2, clkneg, clkneg2) for the external resonant clock driver. It waits a fixed number of adiabatic cycles for the result to propagate, then captures the result and returns it on a valid/ready response channel. It sits between the MIPS25 issue logic and the ALU bit-slice arrays.

---
 rtl/alu_phase_sequencer_if.sv | 25 ++
 rtl/alu_phase_sequencer.sv | 106 ++++++++++
 tb/tb_alu_phase_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_phase_sequencer_if.sv
// Request/response channel between the issue logic and alu_phase_sequencer.
// The issuer drives the request and rsp_ready; the sequencer drives the rest.
interface alu_phase_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_phase_sequencer.sv
// Sequences one operation at a time through the adiabatic ALU, generating the
// four-phase power-clock enables and returning the captured result.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high, ph_en low
// EVAL  | operands held on ALU, ph_en stepping through the four phases
// DONE  | result captured, rsp_valid high until rsp_ready
module alu_phase_sequencer #(
  parameter int WIDTH        = 16,
  parameter int OPW          = 3,
  parameter int PHASE_CYCLES = 4,
  parameter int STAGES       = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_phase_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OPW-1:0]       alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  output logic [3:0]           ph_en,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int SUB_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGES - 1);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ph_idx;
  logic [SUB_W-1:0] sub_cnt;
  logic [STG_W-1:0] stg_cnt;
  logic             accept;
  logic             phase_tc;
  logic             eval_last;
  logic             rsp_fire;

  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = bus.req_valid && (state == IDLE);
  assign phase_tc      = (sub_cnt == SUB_LAST);
  assign eval_last     = (state == EVAL) && phase_tc && (ph_idx == 2'd3) && (stg_cnt == STG_LAST);
  assign rsp_fire      = (state == DONE) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EVAL;
      EVAL:    if (eval_last) state_nxt = DONE;
      DONE:    if (rsp_fire)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      ph_en         <= 4'b0000;
      ph_idx        <= 2'd0;
      sub_cnt       <= '0;
      stg_cnt       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      op_count      <= '0;
    end else if (accept) begin
      alu_a   <= bus.req_a;
      alu_b   <= bus.req_b;
      alu_op  <= bus.req_op;
      ph_idx  <= 2'd0;
      sub_cnt <= '0;
      stg_cnt <= '0;
      ph_en   <= 4'b0001;
    end else if (state == EVAL) begin
      if (!phase_tc) begin
        sub_cnt <= sub_cnt + 1'b1;
      end else begin
        sub_cnt <= '0;
        ph_idx  <= ph_idx + 2'd1;
        if (ph_idx == 2'd3) stg_cnt <= stg_cnt + 1'b1;
        // Rotating the one-hot keeps ph_en registered and glitch-free.
        ph_en   <= eval_last ? 4'b0000 : {ph_en[2:0], ph_en[3]};
      end
      if (eval_last) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= alu_result;
      end
    end else if (rsp_fire) begin
      bus.rsp_valid <= 1'b0;
      op_count      <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_phase_sequencer.sv
// Self-checking bench for alu_phase_sequencer: default instance plus a
// PHASE_CYCLES=1 / STAGES=1 / CNT_W=2 instance; ALU modelled as a & b.
module tb_alu_phase_sequencer;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_phase_sequencer_if #(.WIDTH(16), .OPW(3)) bus ();
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic [3:0]  ph_en;
  logic        busy;
  logic [15:0] op_count;
  assign alu_result = alu_a & alu_b;

  alu_phase_sequencer dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .ph_en(ph_en), .busy(busy), .op_count(op_count)
  );

  alu_phase_sequencer_if #(.WIDTH(16), .OPW(3)) bus_s ();
  logic [15:0] alu_a_s, alu_b_s, alu_result_s;
  logic [2:0]  alu_op_s;
  logic [3:0]  ph_en_s;
  logic        busy_s;
  logic [1:0]  op_count_s;
  assign alu_result_s = alu_a_s & alu_b_s;

  alu_phase_sequencer #(.WIDTH(16), .OPW(3), .PHASE_CYCLES(1), .STAGES(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s),
    .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_op(alu_op_s), .alu_result(alu_result_s),
    .ph_en(ph_en_s), .busy(busy_s), .op_count(op_count_s)
  );

  int checks = 0;
  int passed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_qs[$];
  int exp_count = 0;
  int exp_count_s = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (ph_en !== 4'b0000) $display("FAIL reset_ph_en: got %b want 0000", ph_en); else passed++;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else passed++;
    checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 3'b0) $display("FAIL reset_alu: got %h %h %b want 0 0 0", alu_a, alu_b, alu_op); else passed++;
    checks++; if (op_count !== 16'h0 || bus.rsp_data !== 16'h0) $display("FAIL reset_count_data: got %h %h want 0 0", op_count, bus.rsp_data); else passed++;
    checks++; if (ph_en_s !== 4'b0000 || busy_s !== 1'b0 || op_count_s !== 2'd0) $display("FAIL reset_small: got %b %b %0d want 0000 0 0", ph_en_s, busy_s, op_count_s); else passed++;
  endtask

  task automatic test_phase_pattern();
    logic [3:0]  want;
    logic [15:0] exp;
    bus.req_a = 16'hF0F0; bus.req_b = 16'h0FF0; bus.req_op = 3'b000; bus.req_valid = 1'b1;
    exp_q.push_back(16'hF0F0 & 16'h0FF0);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      want = 4'b0001 << ((k / 4) % 4);
      checks++; if (ph_en !== want) $display("FAIL phase_en k=%0d: got %b want %b", k, ph_en, want); else passed++;
      checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 16'hF0F0) $display("FAIL phase_state k=%0d: got v=%b busy=%b a=%h want 0 1 f0f0", k, bus.rsp_valid, busy, alu_a); else passed++;
      tick();
    end
    checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL phase_rsp_valid: got %b want 1", bus.rsp_valid); else passed++;
    checks++; if (ph_en !== 4'b0000) $display("FAIL phase_done_ph_en: got %b want 0000", ph_en); else passed++;
    exp = exp_q.pop_front();
    checks++; if (bus.rsp_data !== exp) $display("FAIL phase_rsp_data: got %h want %h", bus.rsp_data, exp); else passed++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count++;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL phase_handshake: got v=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready); else passed++;
    checks++; if (op_count !== 16'(exp_count)) $display("FAIL phase_op_count: got %0d want %0d", op_count, exp_count); else passed++;
  endtask

  task automatic test_rsp_hold();
    logic [15:0] exp;
    int n;
    bus.req_a = 16'h5A5A; bus.req_b = 16'h3C3C; bus.req_op = 3'b010; bus.req_valid = 1'b1;
    exp_q.push_back(16'h5A5A & 16'h3C3C);
    tick();
    bus.req_valid = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n !== N + 1) $display("FAIL hold_latency: got %0d want %0d", n, N + 1); else passed++;
    exp = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp) $display("FAIL hold_rsp i=%0d: got v=%b d=%h want 1 %h", i, bus.rsp_valid, bus.rsp_data, exp); else passed++;
      checks++; if (bus.req_ready !== 1'b0 || ph_en !== 4'b0000 || op_count !== 16'(exp_count)) $display("FAIL hold_idle i=%0d: got rdy=%b ph=%b cnt=%0d want 0 0000 %0d", i, bus.req_ready, ph_en, op_count, exp_count); else passed++;
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_count++;
    checks++; if (op_count !== 16'(exp_count) || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL hold_release: got cnt=%0d rdy=%b v=%b want %0d 1 0", op_count, bus.req_ready, bus.rsp_valid, exp_count); else passed++;
  endtask

  task automatic test_req_ignored();
    logic [15:0] exp;
    int n;
    bus.req_a = 16'hAAAA; bus.req_b = 16'hFF0F; bus.req_op = 3'b101; bus.req_valid = 1'b1;
    exp_q.push_back(16'hAAAA & 16'hFF0F);
    tick();
    bus.req_a = 16'h1234; bus.req_b = 16'h00FF; bus.req_op = 3'b011;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin
      checks++; if (alu_a !== 16'hAAAA || alu_op !== 3'b101 || bus.req_ready !== 1'b0) $display("FAIL ignore_eval n=%0d: got a=%h op=%b rdy=%b want aaaa 101 0", n, alu_a, alu_op, bus.req_ready); else passed++;
      tick();
      n++;
    end
    checks++; if (n !== N + 1) $display("FAIL ignore_latency: got %0d want %0d", n, N + 1); else passed++;
    tick();
    checks++; if (alu_a !== 16'hAAAA || bus.rsp_valid !== 1'b1) $display("FAIL ignore_done: got a=%h v=%b want aaaa 1", alu_a, bus.rsp_valid); else passed++;
    exp = exp_q.pop_front();
    checks++; if (bus.rsp_data !== exp) $display("FAIL ignore_rsp_data: got %h want %h", bus.rsp_data, exp); else passed++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count++;
    checks++; if (bus.req_ready !== 1'b1 || alu_a !== 16'hAAAA || op_count !== 16'(exp_count)) $display("FAIL ignore_no_b2b: got rdy=%b a=%h cnt=%0d want 1 aaaa %0d", bus.req_ready, alu_a, op_count, exp_count); else passed++;
    exp_q.push_back(16'h1234 & 16'h00FF);
    tick();
    bus.req_valid = 1'b0;
    checks++; if (alu_a !== 16'h1234 || alu_op !== 3'b011 || ph_en !== 4'b0001 || busy !== 1'b1) $display("FAIL ignore_accept: got a=%h op=%b ph=%b busy=%b want 1234 011 0001 1", alu_a, alu_op, ph_en, busy); else passed++;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n !== N + 1) $display("FAIL ignore_latency2: got %0d want %0d", n, N + 1); else passed++;
    exp = exp_q.pop_front();
    checks++; if (bus.rsp_data !== exp) $display("FAIL ignore_rsp_data2: got %h want %h", bus.rsp_data, exp); else passed++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count++;
    checks++; if (op_count !== 16'(exp_count)) $display("FAIL ignore_op_count: got %0d want %0d", op_count, exp_count); else passed++;
  endtask

  task automatic test_rst_mid();
    logic [15:0] exp;
    int n;
    bus.req_a = 16'hBEEF; bus.req_b = 16'hFFFF; bus.req_op = 3'b001; bus.req_valid = 1'b1;
    exp_q.push_back(16'hBEEF & 16'hFFFF);
    tick();
    bus.req_valid = 1'b0;
    repeat (9) tick();
    checks++; if (busy !== 1'b1 || ph_en !== 4'b0100) $display("FAIL rst_pre: got busy=%b ph=%b want 1 0100", busy, ph_en); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_count = 0;
    exp_count_s = 0;
    checks++; if (ph_en !== 4'b0000 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL rst_mid_state: got ph=%b busy=%b v=%b want 0000 0 0", ph_en, busy, bus.rsp_valid); else passed++;
    checks++; if (alu_a !== 16'h0 || op_count !== 16'h0 || bus.req_ready !== 1'b1) $display("FAIL rst_mid_regs: got a=%h cnt=%0d rdy=%b want 0 0 1", alu_a, op_count, bus.req_ready); else passed++;
    bus.req_a = 16'h0F0F; bus.req_b = 16'h00FF; bus.req_op = 3'b110; bus.req_valid = 1'b1;
    exp_q.push_back(16'h0F0F & 16'h00FF);
    tick();
    bus.req_valid = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n !== N + 1) $display("FAIL rst_after_latency: got %0d want %0d", n, N + 1); else passed++;
    exp = exp_q.pop_front();
    checks++; if (bus.rsp_data !== exp) $display("FAIL rst_after_data: got %h want %h", bus.rsp_data, exp); else passed++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count++;
    checks++; if (op_count !== 16'(exp_count)) $display("FAIL rst_after_count: got %0d want %0d", op_count, exp_count); else passed++;
  endtask

  task automatic test_short_phase();
    logic [3:0]  want;
    logic [15:0] exp;
    bus_s.req_a = 16'hC3C3; bus_s.req_b = 16'h0FF0; bus_s.req_op = 3'b111; bus_s.req_valid = 1'b1;
    exp_qs.push_back(16'hC3C3 & 16'h0FF0);
    tick();
    bus_s.req_valid = 1'b0;
    checks++; if (alu_op_s !== 3'b111 || bus_s.req_ready !== 1'b0) $display("FAIL short_accept: got op=%b rdy=%b want 111 0", alu_op_s, bus_s.req_ready); else passed++;
    for (int k = 0; k < 4; k++) begin
      want = 4'b0001 << k;
      checks++; if (ph_en_s !== want || bus_s.rsp_valid !== 1'b0) $display("FAIL short_phase k=%0d: got ph=%b v=%b want %b 0", k, ph_en_s, bus_s.rsp_valid, want); else passed++;
      tick();
    end
    checks++; if (bus_s.rsp_valid !== 1'b1 || ph_en_s !== 4'b0000) $display("FAIL short_rsp_valid: got v=%b ph=%b want 1 0000", bus_s.rsp_valid, ph_en_s); else passed++;
    exp = exp_qs.pop_front();
    checks++; if (bus_s.rsp_data !== exp) $display("FAIL short_rsp_data: got %h want %h", bus_s.rsp_data, exp); else passed++;
    bus_s.rsp_ready = 1'b1;
    tick();
    bus_s.rsp_ready = 1'b0;
    exp_count_s++;
    checks++; if (op_count_s !== 2'd1 || busy_s !== 1'b0) $display("FAIL short_op_count: got cnt=%0d busy=%b want 1 0", op_count_s, busy_s); else passed++;
  endtask

  task automatic test_count_wrap();
    logic [1:0]  seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [15:0] a, b, exp;
    int n;
    for (int i = 1; i < 5; i++) begin
      a = 16'(i * 16'h1357);
      b = 16'hF00F ^ 16'(i);
      bus_s.req_a = a; bus_s.req_b = b; bus_s.req_op = 3'(i); bus_s.req_valid = 1'b1;
      exp_qs.push_back(a & b);
      tick();
      bus_s.req_valid = 1'b0;
      n = 1;
      while (bus_s.rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n !== 5) $display("FAIL wrap_latency i=%0d: got %0d want 5", i, n); else passed++;
      exp = exp_qs.pop_front();
      checks++; if (bus_s.rsp_data !== exp) $display("FAIL wrap_data i=%0d: got %h want %h", i, bus_s.rsp_data, exp); else passed++;
      bus_s.rsp_ready = 1'b1;
      tick();
      bus_s.rsp_ready = 1'b0;
      exp_count_s++;
      checks++; if (op_count_s !== seq[i]) $display("FAIL wrap_count i=%0d: got %0d want %0d", i, op_count_s, seq[i]); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    bus_s.req_valid = 1'b0; bus_s.req_op = '0; bus_s.req_a = '0; bus_s.req_b = '0; bus_s.rsp_ready = 1'b0;
    test_reset();
    test_phase_pattern();
    test_rsp_hold();
    test_req_ignored();
    test_rst_mid();
    test_short_phase();
    test_count_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1);
  end
endmodule
